// File: rtl/cache_sched_pkg.sv
// Shared types and layer geometry for the dilated-conv cache scheduler.
// Layer l uses dilation 4^l and a 4*4^l entry circular history.
package cache_sched_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RD,
    S_WR,
    S_ISSUE,
    S_WAIT_RES,
    S_OUT
  } state_t;

  localparam int KERNEL_SIZE = 4;

  function automatic int dilation(input int l);
    return 1 << (2 * l);
  endfunction

  function automatic int layer_base(input int l);
    int s;
    s = 0;
    for (int j = 0; j < l; j++)
      s += KERNEL_SIZE * dilation(j);
    return s;
  endfunction

  function automatic int ram_depth(input int n);
    return layer_base(n);
  endfunction

endpackage

// File: rtl/cache_sched_if.sv
// Handshake bundle between the scheduler, its feeder, the MAC
// and the downstream consumer.
interface cache_sched_if #(
  parameter int W          = 16,
  parameter int NUM_LAYERS = 3
);
  import cache_sched_pkg::*;

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [W-1:0]             in_data;
  logic                     taps_valid;
  logic                     taps_ready;
  logic [KERNEL_SIZE*W-1:0] taps_data;
  logic [LW-1:0]            taps_layer;
  logic                     res_valid;
  logic [W-1:0]             res_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [W-1:0]             out_data;
  logic                     err;

  modport master (
    output in_valid, in_data, taps_ready,
    output res_valid, res_data, out_ready,
    input  in_ready, taps_valid, taps_data,
    input  taps_layer, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, taps_ready,
    input  res_valid, res_data, out_ready,
    output in_ready, taps_valid, taps_data,
    output taps_layer, out_valid, out_data, err
  );

endinterface

// File: rtl/cache_ram.sv
// Single-port activation RAM, one access per cycle,
// registered read data, no reset.
module cache_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 84,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we)
        r_mem[i_addr] <= i_wdata;
      else
        o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/cache_scheduler.sv
// Time-multiplexed scheduler: per-layer circular histories in one RAM,
// tap sets handed to an external MAC, result chained to the next layer.
module cache_scheduler
  import cache_sched_pkg::*;
#(
  parameter int W          = 16,
  parameter int NUM_LAYERS = 3
) (
  input logic          clk,
  input logic          rst,
  cache_sched_if.slave bus
);

  localparam int DEPTH = ram_depth(NUM_LAYERS);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TW    = KERNEL_SIZE * W;

  state_t          r_state, w_nxt;
  logic [AW-1:0]   r_clr;
  logic [1:0]      r_k;
  logic [LW-1:0]   r_layer;
  logic [W-1:0]    r_cur;
  logic [W-1:0]    r_out;
  logic [TW-1:0]   r_taps;
  logic            r_in_ready;
  logic            r_taps_valid;
  logic            r_out_valid;
  logic            r_err;

  logic [AW-1:0]   w_head [NUM_LAYERS];
  logic [AW-1:0]   w_base [NUM_LAYERS];
  logic [AW-1:0]   w_dil  [NUM_LAYERS];
  logic [AW-1:0]   w_mask [NUM_LAYERS];
  logic            w_en, w_we, w_last;
  logic [AW-1:0]   w_addr;
  logic [W-1:0]    w_wdata, w_rdata;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_head
    localparam int HW = $clog2(KERNEL_SIZE * dilation(g));
    logic [HW-1:0] r_h;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        r_h <= '0;
      else if (r_state == S_WR && r_layer == LW'(g))
        r_h <= r_h + HW'(1);
    end

    assign w_head[g] = AW'(r_h);
    assign w_base[g] = AW'(layer_base(g));
    assign w_dil[g]  = AW'(dilation(g));
    assign w_mask[g] = AW'(KERNEL_SIZE * dilation(g) - 1);
  end

  cache_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_en),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_nxt   = r_state;
    w_en    = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = r_cur;
    w_last  = (r_layer == LW'(NUM_LAYERS - 1));
    unique case (r_state)
      S_CLEAR: begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_clr;
        w_wdata = '0;
        if (r_clr == AW'(DEPTH - 1))
          w_nxt = S_IDLE;
      end
      S_IDLE:
        if (bus.in_valid)
          w_nxt = S_RD;
      S_RD: begin
        // power-of-two window: masking implements the wrap
        w_en   = 1'b1;
        w_addr = w_base[r_layer]
               + ((w_head[r_layer]
                   - AW'(2'd3 - r_k) * w_dil[r_layer])
                  & w_mask[r_layer]);
        if (r_k == 2'd2)
          w_nxt = S_WR;
      end
      S_WR: begin
        w_en   = 1'b1;
        w_we   = 1'b1;
        w_addr = w_base[r_layer] + w_head[r_layer];
        w_nxt  = S_ISSUE;
      end
      S_ISSUE:
        if (bus.taps_ready)
          w_nxt = S_WAIT_RES;
      S_WAIT_RES:
        if (bus.res_valid)
          w_nxt = w_last ? S_OUT : S_RD;
      S_OUT:
        if (bus.out_ready)
          w_nxt = S_IDLE;
      default:
        w_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_CLEAR;
      r_clr        <= '0;
      r_k          <= '0;
      r_layer      <= '0;
      r_cur        <= '0;
      r_out        <= '0;
      r_taps       <= '0;
      r_in_ready   <= 1'b0;
      r_taps_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_in_ready   <= (w_nxt == S_IDLE);
      r_taps_valid <= (w_nxt == S_ISSUE);
      r_out_valid  <= (w_nxt == S_OUT);
      if (bus.res_valid && r_state != S_WAIT_RES)
        r_err <= 1'b1;
      case (r_state)
        S_CLEAR:
          r_clr <= r_clr + AW'(1);
        S_IDLE:
          if (bus.in_valid) begin
            r_cur   <= bus.in_data;
            r_layer <= '0;
            r_k     <= '0;
          end
        S_RD: begin
          // read data trails its address by one cycle
          r_k <= r_k + 2'd1;
          if (r_k == 2'd1)
            r_taps[0 +: W] <= w_rdata;
          if (r_k == 2'd2)
            r_taps[W +: W] <= w_rdata;
        end
        S_WR: begin
          r_taps[2*W +: W] <= w_rdata;
          r_taps[3*W +: W] <= r_cur;
        end
        S_WAIT_RES:
          if (bus.res_valid) begin
            r_cur <= bus.res_data;
            r_k   <= '0;
            if (w_last)
              r_out <= bus.res_data;
            else
              r_layer <= r_layer + LW'(1);
          end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.taps_valid = r_taps_valid;
  assign bus.taps_data  = r_taps;
  assign bus.taps_layer = r_layer;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_cache_scheduler.sv
// Bench for cache_scheduler: two layers, identity MAC with 2-cycle
// latency, randomized samples and stalls against a history model.
module tb_cache_scheduler;
  import cache_sched_pkg::*;

  localparam int W  = 16;
  localparam int NL = 2;
  localparam int DEPTH = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_sched_if #(.W(W), .NUM_LAYERS(NL)) bus ();

  cache_scheduler #(.W(W), .NUM_LAYERS(NL)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int inj_req = 0;
  logic [W-1:0] hist [$];

  // identity MAC: result = newest tap, two cycles after handshake
  initial begin : mac
    int pend;
    int inj_ack;
    logic [W-1:0] pd;
    pend = 0;
    inj_ack = 0;
    pd = '0;
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    forever begin
      @(negedge clk);
      bus.res_valid = 1'b0;
      if (rst !== 1'b1) begin
        pend = 0;
        inj_ack = inj_req;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.res_valid = 1'b1;
            bus.res_data = pd;
          end
        end
        if (inj_req != inj_ack) begin
          inj_ack = inj_req;
          bus.res_valid = 1'b1;
          bus.res_data = 16'h5a5a;
        end
        if (bus.taps_valid && bus.taps_ready) begin
          pend = 2;
          pd = bus.taps_data[3*W +: W];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return bus.in_ready;
      1: return bus.taps_valid;
      default: return bus.out_valid;
    endcase
  endfunction

  task automatic wait_for(input int which, output bit ok);
    int n;
    n = 0;
    while (sig(which) !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    ok = (sig(which) === 1'b1);
  endtask

  // tap k of layer l is the layer input (3-k)*D samples back
  function automatic logic [4*W-1:0] exp_taps(input int l);
    logic [4*W-1:0] t;
    int n, idx;
    t = '0;
    n = hist.size() - 1;
    for (int k = 0; k < 4; k++) begin
      idx = n - (3 - k) * dilation(l);
      if (idx >= 0)
        t[k*W +: W] = hist[idx];
    end
    return t;
  endfunction

  task automatic process_sample(input logic [W-1:0] x,
                                input int ts, input int os);
    bit ok;
    logic [4*W-1:0] e;
    logic [W-1:0] eo;
    hist.push_back(x);
    e = '0;
    wait_for(0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_wait: in_ready=0 required 1");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data = x;
    tick();
    bus.in_valid = 1'b0;
    for (int l = 0; l < NL; l++) begin
      bus.taps_ready = (ts == 0);
      wait_for(1, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL taps_wait: layer %0d taps_valid=0 required 1", l);
        bus.taps_ready = 1'b1;
        return;
      end
      e = exp_taps(l);
      checks++;
      if (bus.taps_data !== e || bus.taps_layer !== 1'(l)) begin
        errors++;
        $display("FAIL taps: layer %0d got %h/%0d required %h/%0d",
                 l, bus.taps_data, bus.taps_layer, e, l);
      end
      for (int c = 0; c < ts; c++) begin
        tick();
        checks++;
        if (bus.taps_valid !== 1'b1 || bus.taps_data !== e ||
            bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL taps_hold: v=%b d=%h rdy=%b required 1 %h 0",
                   bus.taps_valid, bus.taps_data, bus.in_ready, e);
        end
      end
      bus.taps_ready = 1'b1;
      tick();
    end
    eo = e[3*W +: W];
    bus.out_ready = (os == 0);
    wait_for(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL out_wait: out_valid=0 required 1");
      bus.out_ready = 1'b1;
      return;
    end
    checks++;
    if (bus.out_data !== eo) begin
      errors++;
      $display("FAIL out_data: got %h required %h", bus.out_data, eo);
    end
    for (int c = 0; c < os; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== eo ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL out_hold: v=%b d=%h rdy=%b required 1 %h 0",
                 bus.out_valid, bus.out_data, bus.in_ready, eo);
      end
    end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({bus.in_ready, bus.taps_valid, bus.out_valid, bus.err} !== 4'b0) begin
      errors++;
      $display("FAIL %s_ctl: rdy/tv/ov/err=%b%b%b%b required 0000", tag,
               bus.in_ready, bus.taps_valid, bus.out_valid, bus.err);
    end
    checks++;
    if (bus.taps_data !== '0 || bus.taps_layer !== '0 ||
        bus.out_data !== '0) begin
      errors++;
      $display("FAIL %s_data: taps=%h layer=%0d out=%h required 0", tag,
               bus.taps_data, bus.taps_layer, bus.out_data);
    end
  endtask

  task automatic release_and_clear(input string tag);
    int n, nz;
    hist.delete();
    rst = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.in_ready !== 1'b1 && n < 100);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL %s_clear_len: in_ready rose after %0d required %0d",
               tag, n, DEPTH);
    end
    nz = 0;
    for (int i = 0; i < DEPTH; i++)
      if (u_dut.u_ram.r_mem[i] !== '0)
        nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL %s_ram_zero: %0d nonzero entries required 0", tag, nz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    release_and_clear("reset");
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 40; i++)
      process_sample(W'(i), 0, 0);
  endtask

  task automatic test_stall();
    process_sample(W'($urandom), 10, 10);
    process_sample(W'($urandom), 0, 0);
  endtask

  task automatic test_err();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: err=%b required 0", bus.err);
    end
    inj_req++;
    tick();
    tick();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b required 1", bus.err);
    end
    process_sample(W'($urandom), 0, 0);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b required 1", bus.err);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++)
      process_sample(W'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3));
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_for(0, ok);
    bus.in_valid = 1'b1;
    bus.in_data = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    for (int l = 0; l < NL; l++) begin
      wait_for(1, ok);
      checks++;
      if (!ok || bus.taps_layer !== 1'(l)) begin
        errors++;
        $display("FAIL mid_layer: ok=%b layer=%0d required 1 %0d",
                 ok, bus.taps_layer, l);
      end
      tick();
    end
    rst = 1'b0;
    #2;
    check_reset_outputs("mid");
    tick();
    release_and_clear("mid");
    process_sample(16'd7, 0, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.taps_ready = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_scheduler.md
# cache_scheduler

Time-multiplexed controller for a stack of dilated causal conv layers sharing one activation RAM and one external MAC unit. It accepts one input sample at a time and holds a per-layer circular history in a single RAM. For each layer in turn it fetches the four kernel taps, hands them to the MAC, and feeds the MAC result forward as the next layer's input. The final layer's result is emitted downstream. It replaces one-cache-per-layer register arrays when layer count or dilation makes flops too costly.

## Interface
- W, 16: element width, signed two's complement.
- NUM_LAYERS, 3: number of conv layers; kernel size fixed at 4.
- Layer l has dilation D(l) = 4^l and cache depth 4·D(l).
- Derived RAM depth = Σ 4·4^l (NUM_LAYERS=3 → 84).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample offered.
- in_ready  out  1  scheduler can accept a sample.
- in_data  in  W  input sample.
- taps_valid  out  1  tap set presented to MAC.
- taps_ready  in  1  MAC accepts tap set.
- taps_data  out  W×4  [0]=x[n-3D], [1]=x[n-2D], [2]=x[n-D], [3]=x[n].
- taps_layer  out  $clog2(NUM_LAYERS)  layer index of presented taps.
- res_valid  in  1  single-cycle MAC result strobe; no backpressure.
- res_data  in  W  MAC result for layer taps_layer.
- out_valid  out  1  final-layer result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  final-layer result.
- err  out  1  sticky; set by res_valid outside WAIT_RES.

## Operation
- Every state-machine cycle handles at most one RAM access.
- CLEAR (entered at reset release):
  - Writes 0 to every RAM address, ascending, one per cycle.
  - in_ready stays low throughout; goes to IDLE after the last address.
- IDLE:
  - in_ready=1; on in_valid, latch in_data as cur, set layer=0, go to RD.
- RD:
  - Issues reads for taps k=0,1,2 on three consecutive cycles.
  - Address = base(l) + ((head(l) − (3−k)·D(l)) & (4·D(l)−1)).
  - Wrap is a power-of-two mask; no compare.
  - base(l) = Σ_{j<l} 4·4^j.
- WR:
  - Captures tap2 read data; writes cur to base(l)+head(l).
  - head(l) ← head(l)+1 modulo 4·D(l).
  - Reads always precede the write, so the overwritten slot is never a live tap.
- ISSUE:
  - taps_valid=1 with taps_data={t0,t1,t2,cur}; hold stable until taps_ready.
  - Go to WAIT_RES on the handshake cycle.
- WAIT_RES:
  - On res_valid: cur ← res_data.
  - If l < NUM_LAYERS−1: l++, go to RD.
  - Else: go to OUT.
- OUT:
  - out_valid=1, out_data=cur; hold until out_ready, then go to IDLE.
- Arithmetic: the block does no data arithmetic. Head counters per layer are $clog2(4·D(l)) bits.
- res_valid in any state other than WAIT_RES is ignored and sets err. Only reset clears err.
- Reset mid-operation:
  - The in-flight sample is dropped, heads and err go to 0, and the block reruns CLEAR.
  - History is lost by design.

## Timing
- Reset values:
  - in_ready=0, taps_valid=0, out_valid=0, err=0.
  - taps_data=0, taps_layer=0, out_data=0.
  - All heads 0; state CLEAR.
- CLEAR lasts exactly RAM-depth cycles; in_ready rises on the following cycle (84 for default).
- RAM: synchronous read, 1-cycle latency.
- Per layer: 3 RD + 1 WR + 1 ISSUE minimum, plus MAC latency.
- Input-accept to out_valid = NUM_LAYERS·(5 + MAC latency) cycles when taps_ready and out_ready are tied high.
- All outputs registered.
- in_ready is low in every state except IDLE; no input skid.

## Structure
- Package cache_sched_pkg:
  - state enum (CLEAR, IDLE, RD, WR, ISSUE, WAIT_RES, OUT);
  - KERNEL_SIZE=4;
  - constant functions dilation(l), layer_base(l), ram_depth(NUM_LAYERS).
- Sub-module cache_ram: single-port synchronous RAM, W wide, ram_depth entries, 1-cycle read, no reset.
- Heads: generate-loop array of per-layer counters.

## Test plan
Use NUM_LAYERS=2 (D=1,4; depth 20) and an identity MAC (res_data=taps_data[3], 2-cycle latency).

- Release reset → in_ready stays 0 for 20 cycles, then 1; all RAM entries read back 0.
- Feed 1,2,3,… → at sample n:
  - layer 0 taps = {n−3,n−2,n−1,n} (values <1 shown as 0);
  - layer 1 taps = {n−12,n−8,n−4,n}.
- Feed 40 samples → layer-1 head wraps past 15; taps remain {n−12,n−8,n−4,n} through wrap, with no stale data.
- Hold taps_ready=0 for 10 cycles, then hold out_ready=0 for 10 cycles:
  - taps and out_data stay stable;
  - in_ready stays 0;
  - no sample is lost.
- Pulse res_valid during IDLE → err=1 and stays 1; the next sample still processes correctly.
- Assert rst while in WAIT_RES on layer 1:
  - all outputs return to reset values and CLEAR reruns;
  - next input 7 gives layer-0 taps {0,0,0,7}.
